// File: rtl/ocr_pkg.sv
// Shared widths and FSM encoding for the OCR character-centroid datapath.
package ocr_pkg;

  localparam int COORD_W = 4;
  localparam int CNT_W   = 8;
  localparam int SUM_W   = 12;
  localparam int RECIP_W = 17;
  localparam int RES_W   = 8;
  localparam int PROD_W  = SUM_W + RECIP_W;

  // Q0 sum times Q1.16 reciprocal: bits [19:12] of the product hold the Q4.4 result.
  localparam int FRAC_SH = 12;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    LOOKUP,
    MULX,
    MULY,
    HOLD
  } state_e;

endpackage

// File: rtl/centroid_calc_if.sv
// Pixel stream, reciprocal ROM and result handshake of centroid_calc.
interface centroid_calc_if;
  import ocr_pkg::*;

  logic               sof;
  logic               eof;
  logic               pix_valid;
  logic               pix_fg;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               in_ready;

  logic [CNT_W-1:0]   n_out;
  logic [RECIP_W-1:0] recip_in;

  logic [RES_W-1:0]   cx;
  logic [RES_W-1:0]   cy;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               sat;
  logic               c_valid;
  logic               c_ready;

  modport slave (
    input  sof, eof, pix_valid, pix_fg, pix_x, pix_y, recip_in, c_ready,
    output in_ready, n_out, cx, cy, count, empty, sat, c_valid
  );

  modport master (
    output sof, eof, pix_valid, pix_fg, pix_x, pix_y, recip_in, c_ready,
    input  in_ready, n_out, cx, cy, count, empty, sat, c_valid
  );

endinterface

// File: rtl/centroid_calc_recip_mul.sv
// Registered sum * reciprocal multiply, sliced to Q4.4.
// Define CENTROID_ROUND_EN to round half up instead of truncating.
module recip_mul
  import ocr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SUM_W-1:0]   sum_i,
  input  logic [RECIP_W-1:0] recip_i,
  output logic [RES_W-1:0]   res_o
);

`ifdef CENTROID_ROUND_EN
  localparam logic [PROD_W-1:0] ROUND_HALF = PROD_W'(1) << (FRAC_SH - 1);
`endif

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_adj;
  logic [RES_W-1:0]  res_d;
  logic [RES_W-1:0]  res_q;
  logic              prod_unused;

  always_comb begin
    prod = PROD_W'(sum_i) * PROD_W'(recip_i);
`ifdef CENTROID_ROUND_EN
    prod_adj = prod + ROUND_HALF;
`else
    prod_adj = prod;
`endif
    res_d = prod_adj[FRAC_SH +: RES_W];
  end

  // Sum never exceeds 15*N, so the bits above the slice stay zero.
  assign prod_unused = ^{prod_adj[PROD_W-1:FRAC_SH+RES_W], prod_adj[FRAC_SH-1:0]};

  // NOTE: registers take <= so every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: rtl/centroid_calc.sv
// Foreground-pixel centroid of a 16x16 character window, Q4.4 result.
// Rounding mode is selected by CENTROID_ROUND_EN inside recip_mul.
module centroid_calc
  import ocr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  centroid_calc_if.slave bus
);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_x_q, sum_x_d;
  logic [SUM_W-1:0] sum_y_q, sum_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_acc_q, sat_acc_d;
  logic [RES_W-1:0] cx_q, cx_d;
  logic [RES_W-1:0] cy_q, cy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             sat_q, sat_d;
  logic             c_valid_q, c_valid_d;

  logic             in_ready;
  logic             accept;
  logic [SUM_W-1:0] mul_sum;
  logic [RES_W-1:0] mul_res;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = bus.pix_valid & in_ready;
  assign mul_sum  = (state_q == MULX) ? sum_x_q : sum_y_q;

  recip_mul u_recip_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .sum_i   (mul_sum),
    .recip_i (bus.recip_in),
    .res_o   (mul_res)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    sum_x_d   = sum_x_q;
    sum_y_d   = sum_y_q;
    cnt_d     = cnt_q;
    sat_acc_d = sat_acc_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    count_d   = count_q;
    empty_d   = empty_q;
    sat_d     = sat_q;
    c_valid_d = 1'b0;

    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept && (bus.sof || state_q == ACCUM)) begin
          if (bus.sof) begin
            sum_x_d   = '0;
            sum_y_d   = '0;
            cnt_d     = '0;
            sat_acc_d = 1'b0;
          end
          if (bus.pix_fg) begin
            if (cnt_d != CNT_MAX) begin
              sum_x_d = sum_x_d + SUM_W'(bus.pix_x);
              sum_y_d = sum_y_d + SUM_W'(bus.pix_y);
              cnt_d   = cnt_d + 1'b1;
            end else begin
              sat_acc_d = 1'b1;
            end
          end
          state_d = ACCUM;
          if (bus.eof) begin
            count_d = cnt_d;
            sat_d   = sat_acc_d;
            empty_d = (cnt_d == '0);
            if (cnt_d == '0) begin
              cx_d    = '0;
              cy_d    = '0;
              state_d = HOLD;
            end else begin
              state_d = LOOKUP;
            end
          end
        end
      end
      LOOKUP: state_d = MULX;
      MULX:   state_d = MULY;
      MULY: begin
        cx_d    = mul_res;
        state_d = HOLD;
      end
      HOLD: begin
        // First HOLD cycle collects the y product; c_valid rises one edge later.
        if (c_valid_q && bus.c_ready) begin
          state_d = IDLE;
        end else begin
          c_valid_d = 1'b1;
          if (!c_valid_q && !empty_q) cy_d = mul_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      count_q   <= '0;
      empty_q   <= 1'b0;
      sat_q     <= 1'b0;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      cnt_q     <= cnt_d;
      sat_acc_q <= sat_acc_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      sat_q     <= sat_d;
      c_valid_q <= c_valid_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.n_out    = (state_q inside {LOOKUP, MULX, MULY}) ? cnt_q : '0;
  assign bus.cx       = cx_q;
  assign bus.cy       = cy_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_q;
  assign bus.sat      = sat_q;
  assign bus.c_valid  = c_valid_q;

endmodule

// File: tb/tb_centroid_calc.sv
// Self-checking bench for centroid_calc: directed corner frames plus random frames
// against an arithmetic centroid model and a registered 1/N ROM model.
module tb_centroid_calc;
  import ocr_pkg::*;

  typedef struct {
    bit         fg;
    logic [3:0] x;
    logic [3:0] y;
  } beat_t;

`ifdef CENTROID_ROUND_EN
  localparam int RND = 2048;
`else
  localparam int RND = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  centroid_calc_if ccif ();

  centroid_calc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ccif.slave)
  );

  // Reciprocal ROM with one cycle of read latency.
  always @(posedge clk)
    ccif.recip_in <= (ccif.n_out == 8'd0) ? 17'd0 : 17'(65536 / int'(ccif.n_out));

  int n_checks = 0;
  int n_errors = 0;

  beat_t frame_q[$];

  int         exp_cnt, exp_lat;
  logic [7:0] exp_cx, exp_cy;
  bit         exp_sat, exp_empty;
  logic [7:0] obs_cx, obs_cy, obs_count;
  bit         obs_sat, obs_empty;
  int         obs_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(input bit fg, input int x, input int y);
    beat_t b;
    b.fg = fg;
    b.x  = 4'(x);
    b.y  = 4'(y);
    return b;
  endfunction

  function automatic beat_t rand_beat();
    return mk(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endfunction

  // Centroid straight from the frame contents: first 255 ink pixels count.
  task automatic model();
    int sx, sy, fgs;
    int px, py, recip;
    sx = 0; sy = 0; fgs = 0; exp_cnt = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i].fg) begin
        fgs++;
        if (exp_cnt < 255) begin
          exp_cnt++;
          sx += int'(frame_q[i].x);
          sy += int'(frame_q[i].y);
        end
      end
    end
    exp_sat   = (fgs > 255);
    exp_empty = (exp_cnt == 0);
    if (exp_empty) begin
      exp_cx  = 8'd0;
      exp_cy  = 8'd0;
      exp_lat = 1;
    end else begin
      recip   = 65536 / exp_cnt;
      px      = sx * recip + RND;
      py      = sy * recip + RND;
      exp_cx  = 8'(px / 4096);
      exp_cy  = 8'(py / 4096);
      exp_lat = 4;
    end
  endtask

  task automatic drive_beat(input bit sof, input bit eof, input beat_t b);
    @(negedge clk);
    ccif.pix_valid = 1'b1;
    ccif.sof       = sof;
    ccif.eof       = eof;
    ccif.pix_fg    = b.fg;
    ccif.pix_x     = b.x;
    ccif.pix_y     = b.y;
    @(posedge clk);
  endtask

  // Idle cycle with loud-looking but unqualified control bits.
  task automatic drive_gap();
    @(negedge clk);
    ccif.pix_valid = 1'b0;
    ccif.sof       = 1'b1;
    ccif.eof       = 1'b1;
    ccif.pix_fg    = 1'b1;
    ccif.pix_x     = 4'($urandom);
    ccif.pix_y     = 4'($urandom);
    @(posedge clk);
  endtask

  task automatic play_frame(input bit idle_junk, input bit restart);
    beat_t b;
    if (idle_junk) begin
      for (int i = 0; i < 2; i++) begin
        b = rand_beat();
        b.fg = 1'b1;
        drive_beat(1'b0, i[0], b);
      end
    end
    if (restart) begin
      b = rand_beat();
      b.fg = 1'b1;
      drive_beat(1'b1, 1'b0, b);
      for (int i = 0; i < 3; i++) begin
        b = rand_beat();
        b.fg = 1'b1;
        drive_beat(1'b0, 1'b0, b);
      end
    end
    foreach (frame_q[i]) begin
      if (i != 0 && $urandom_range(0, 3) == 0) drive_gap();
      drive_beat(i == 0, i == frame_q.size() - 1, frame_q[i]);
    end
  endtask

  // Entered right after the edge that accepted eof.
  task automatic finish_frame(input int hold_cycles);
    int lat;
    bit nz_seen;
    model();
    @(negedge clk);
    ccif.pix_valid = 1'b1;
    ccif.sof       = 1'b0;
    ccif.eof       = 1'b1;
    ccif.pix_fg    = 1'b1;
    ccif.pix_x     = 4'($urandom);
    ccif.pix_y     = 4'($urandom);
    check("n_out_after_eof", ccif.n_out, exp_empty ? 0 : exp_cnt);
    check("in_ready_busy", ccif.in_ready, 0);
    lat = 0;
    nz_seen = (ccif.n_out != 8'd0);
    while (ccif.c_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ccif.n_out != 8'd0) nz_seen = 1'b1;
    end
    if (exp_empty) check("n_out_stays_zero", nz_seen, 0);
    check("latency", lat, exp_lat);
    check("cx", ccif.cx, exp_cx);
    check("cy", ccif.cy, exp_cy);
    check("count", ccif.count, exp_cnt);
    check("empty", ccif.empty, exp_empty);
    check("sat", ccif.sat, exp_sat);
    check("cx_range", ccif.cx <= 8'hF0, 1);
    check("in_ready_hold", ccif.in_ready, 0);
    obs_cx = ccif.cx; obs_cy = ccif.cy; obs_count = ccif.count;
    obs_sat = ccif.sat; obs_empty = ccif.empty; obs_lat = lat;
    for (int i = 0; i < hold_cycles; i++) begin
      ccif.sof = 1'b1;
      ccif.eof = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold_c_valid", ccif.c_valid, 1);
      check("hold_in_ready", ccif.in_ready, 0);
      check("hold_cx", ccif.cx, exp_cx);
      check("hold_cy", ccif.cy, exp_cy);
      check("hold_count", ccif.count, exp_cnt);
    end
    ccif.pix_valid = 1'b0;
    ccif.c_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ccif.c_ready = 1'b0;
    check("release_c_valid", ccif.c_valid, 0);
    check("release_in_ready", ccif.in_ready, 1);
  endtask

  task automatic rand_frame(input int len, input int density);
    beat_t b;
    frame_q = {};
    for (int i = 0; i < len; i++) begin
      b = rand_beat();
      b.fg = ($urandom_range(1, 3) <= density);
      frame_q.push_back(b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ccif.pix_valid = 1'b0;
    ccif.sof = 1'b0; ccif.eof = 1'b0; ccif.pix_fg = 1'b0;
    ccif.pix_x = 4'd0; ccif.pix_y = 4'd0;
    ccif.c_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_c_valid", ccif.c_valid, 0);
    check("rst_n_out", ccif.n_out, 0);
    check("rst_count", ccif.count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", ccif.in_ready, 1);

    // Single pixel, sof and eof on the same beat, N=1.
    frame_q = {};
    frame_q.push_back(mk(1'b1, 5, 9));
    play_frame(1'b0, 1'b0);
    finish_frame(1);
    check("single_cx", obs_cx, 8'h50);
    check("single_cy", obs_cy, 8'h90);
    check("single_count", obs_count, 1);
    check("single_lat", obs_lat, 4);

    // Two pixels, N=2.
    frame_q = {};
    frame_q.push_back(mk(1'b1, 2, 3));
    frame_q.push_back(mk(1'b1, 5, 8));
    play_frame(1'b1, 1'b0);
    finish_frame(0);
    check("pair_cx", obs_cx, 8'h38);
    check("pair_cy", obs_cy, 8'h58);

    // N=3, x sum 1: both modes agree.
    frame_q = {};
    frame_q.push_back(mk(1'b1, 0, 0));
    frame_q.push_back(mk(1'b1, 0, 0));
    frame_q.push_back(mk(1'b1, 1, 0));
    play_frame(1'b0, 1'b0);
    finish_frame(0);
    check("third_cx", obs_cx, 8'h05);

    // N=3, x sum 2: rounding changes the answer.
    frame_q = {};
    frame_q.push_back(mk(1'b1, 0, 0));
    frame_q.push_back(mk(1'b1, 1, 0));
    frame_q.push_back(mk(1'b1, 1, 0));
    play_frame(1'b0, 1'b0);
    finish_frame(0);
`ifdef CENTROID_ROUND_EN
    check("two_thirds_cx", obs_cx, 8'h0B);
`else
    check("two_thirds_cx", obs_cx, 8'h0A);
`endif

    // All-background frame.
    frame_q = {};
    for (int i = 0; i < 12; i++) frame_q.push_back(mk(1'b0, i, 15 - i));
    play_frame(1'b1, 1'b0);
    finish_frame(2);
    check("bg_empty", obs_empty, 1);
    check("bg_cx", obs_cx, 0);
    check("bg_lat", obs_lat, 1);

    // 300 ink pixels saturate the count.
    rand_frame(300, 3);
    play_frame(1'b0, 1'b0);
    finish_frame(0);
    check("sat_count", obs_count, 255);
    check("sat_flag", obs_sat, 1);

    // Reset pulsed while the x product is being formed.
    rand_frame(6, 2);
    frame_q[0].fg = 1'b1;
    play_frame(1'b0, 1'b0);
    model();
    @(negedge clk);
    ccif.pix_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mulx_n_out", ccif.n_out, exp_cnt);
    rst_n = 1'b0;
    #1;
    check("mulx_rst_n_out", ccif.n_out, 0);
    check("mulx_rst_cx", ccif.cx, 0);
    check("mulx_rst_cy", ccif.cy, 0);
    check("mulx_rst_count", ccif.count, 0);
    check("mulx_rst_empty", ccif.empty, 0);
    check("mulx_rst_sat", ccif.sat, 0);
    check("mulx_rst_c_valid", ccif.c_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mulx_rst_in_ready", ccif.in_ready, 1);
    rand_frame(9, 2);
    frame_q[3].fg = 1'b1;
    play_frame(1'b0, 1'b0);
    finish_frame(1);

    // Consumer stalls for ten cycles.
    rand_frame(7, 3);
    play_frame(1'b0, 1'b0);
    finish_frame(10);

    // Random frames, some with junk before sof or a discarded partial frame.
    for (int f = 0; f < 20; f++) begin
      rand_frame(int'($urandom_range(1, 40)), int'($urandom_range(0, 3)));
      play_frame(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      finish_frame(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/centroid_calc.md
CENTROID_CALC -- requirements
Module: centroid_calc

Interface
REQ-001 clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 sof  in  1  start of frame; qualified by pix_valid; clears the accumulators and the count for a new character window.
REQ-004 eof  in  1  last pixel of the frame; qualified by pix_valid.
REQ-005 pix_valid  in  1  pixel beat valid.
REQ-006 pix_fg  in  1  1 = foreground (ink) pixel.
REQ-007 pix_x, pix_y  in  4 each  pixel coordinates within the 16x16 window.
REQ-008 in_ready  out  1  beats are accepted only when pix_valid & in_ready.
REQ-009 n_out  out  8  foreground count driven to the 1/N reciprocal ROM.
REQ-010 recip_in  in  17  reciprocal from the ROM, unsigned Q1.16 (floor(65536/N)); treated as valid one cycle after n_out is stable.
REQ-011 cx, cy  out  8 each  centroid, unsigned Q4.4.
REQ-012 count  out  8  foreground count of the reported frame.
REQ-013 empty, sat  out  1 each  count = 0; count saturated.
REQ-014 c_valid  out  1, c_ready  in  1  result handshake; a transfer occurs when both are 1.

Function
REQ-015 FSM states: IDLE, ACCUM, LOOKUP, MULX, MULY, HOLD.
REQ-016 IDLE/ACCUM: in_ready=1. An accepted beat with sof enters ACCUM with sum_x, sum_y and cnt cleared, and that beat counts as the first pixel.
REQ-017 Accepted beats in IDLE without sof are ignored.
REQ-018 Each accepted beat with pix_fg=1 and cnt<255 does: sum_x+=pix_x, sum_y+=pix_y, cnt+=1. Sums are 12 bits unsigned.
REQ-019 A foreground beat arriving when cnt=255 sets sat=1 and leaves the sums and cnt unchanged.
REQ-020 An accepted beat with eof, including a beat with sof and eof together, applies its own pixel and then goes to LOOKUP if the final cnt>0, or to HOLD with empty=1, cx=cy=0 if cnt=0.
REQ-021 sof received in ACCUM restarts accumulation; the previous frame is discarded.
REQ-022 n_out is held at cnt from LOOKUP through MULY. LOOKUP lasts exactly one cycle.
REQ-023 MULX: product = sum_x * recip_in (29 bits), cx = product[19:12]. MULY does the same for cy.
REQ-024 Latency: for eof accepted at edge t, c_valid=1 after edge t+4. For an empty frame, c_valid=1 after edge t+1.
REQ-025 HOLD: c_valid=1, in_ready=0, and all outputs are stable until c_ready=1. Then go to IDLE with c_valid=0.
REQ-026 in_ready=0 in LOOKUP, MULX, MULY and HOLD. Beats in those states are not consumed.

Reset
REQ-027 rst_n low, at any time including mid-frame or mid-multiply: state=IDLE; sums, cnt, n_out, cx, cy, count, empty, sat and c_valid = 0; in_ready=1 after release.

Configuration
REQ-028 With CENTROID_ROUND_EN defined, 0x800 is added to the product before slicing (round half up). Without it, the result is truncated. The result never exceeds 0xF0 in either mode.

Structure
REQ-029 Package ocr_pkg holds: COORD_W=4, CNT_W=8, SUM_W=12, RECIP_W=17, the Q4.4 result width, and the FSM state enum.
REQ-030 One sub-module, recip_mul: a registered 12x17 unsigned multiply with rounding/slice. It is shared between MULX and MULY.

Verification
REQ-031 Single fg pixel (5,9), sof+eof on the same beat, recip_in=65536 -> cx=0x50, cy=0x90, count=1, c_valid after 4 edges.
REQ-032 fg pixels (2,3) and (5,8), recip_in=32768 -> cx=0x38, cy=0x58.
REQ-033 Frame of 3 fg pixels at x={0,0,1}, recip_in=21845 -> cx=0x05 with CENTROID_ROUND_EN, 0x05 without. Also check a case where the two modes differ: x sum=2, N=3 -> 0x0B vs 0x0A.
REQ-034 All-background frame -> empty=1, cx=cy=0, n_out never leaves 0, c_valid one edge after eof.
REQ-035 300 fg pixels -> count=255, sat=1. Separately, rst_n pulsed in MULX -> all outputs 0, in_ready=1, the next frame is correct.
REQ-036 c_ready held 0 for 10 cycles -> outputs stable, beats ignored, in_ready=0; release -> IDLE next edge.
